branch_cmp: RTL and testbench

Branch-condition comparator for the EX stage, with a built-in result checker. The combinational core evaluates one of six RISC-V branch relations (EQ, NE, LT, GE, LTU, GEU) between two WIDTH-bit operands and drives the branch-taken flag. A clocked wrapper registers that flag. It also provides a toggle-triggered checker that grades the flag against an expected value, for in-system self-test.

---
 rtl/branch_cmp.sv | 88 ++++++++
 tb/tb_branch_cmp.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - RISC-V branch-condition comparator with registered flag and toggle-triggered checker
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   arg0, arg1          WIDTH-bit operands
//   op                  funct3 relation select (000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU)
//   true                combinational relation result
//   true_q              true registered once per clk
//   check               grading trigger, every level change requests one grading
//   exp_val             expected value of true
//   chk_op              0: pass when true == exp_val, 1: pass when true != exp_val
//   is_right            registered grading result
//   is_right_vld        one-cycle pulse marking a new is_right
module branch_cmp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] arg0,
    input  logic [WIDTH-1:0] arg1,
    input  logic [2:0]       op,
    output logic             true,
    output logic             true_q,
    input  logic             check,
    input  logic             exp_val,
    input  logic             chk_op,
    output logic             is_right,
    output logic             is_right_vld
);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    logic eq;
    logic ltu;
    logic lts;
    logic check_d;
    logic armed;
    logic toggle;
    logic pass;

    assign eq  = (arg0 == arg1);
    assign ltu = (arg0 < arg1);
    // Differing sign bits decide the signed order outright; otherwise the
    // unsigned magnitude order is also the signed order.
    assign lts = (arg0[WIDTH-1] != arg1[WIDTH-1]) ? arg0[WIDTH-1] : ltu;

    always_comb begin
        true = 1'b0;
        case (op)
            OP_EQ:   true = eq;
            OP_NE:   true = !eq;
            OP_LT:   true = lts;
            OP_GE:   true = !lts;
            OP_LTU:  true = ltu;
            OP_GEU:  true = !ltu;
            default: true = 1'b0;
        endcase
    end

    // armed masks the first clock after reset so the level check held
    // during reset is only captured into check_d, never graded.
    assign toggle = armed && (check != check_d);
    assign pass   = chk_op ? (true != exp_val) : (true == exp_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            true_q       <= 1'b0;
            check_d      <= 1'b0;
            armed        <= 1'b0;
            is_right     <= 1'b0;
            is_right_vld <= 1'b0;
        end else begin
            true_q       <= true;
            check_d      <= check;
            armed        <= 1'b1;
            is_right_vld <= toggle;
            if (toggle) begin
                is_right <= pass;
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp.sv
// tb/tb_branch_cmp.sv - directed self-checking bench for branch_cmp
module tb_branch_cmp;

    logic        clk;
    logic        reset;
    logic [31:0] arg0;
    logic [31:0] arg1;
    logic [2:0]  op;
    logic        true;
    logic        true_q;
    logic        check;
    logic        exp_val;
    logic        chk_op;
    logic        is_right;
    logic        is_right_vld;

    int tests_run;
    int tests_failed;

    branch_cmp #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .arg0         (arg0),
        .arg1         (arg1),
        .op           (op),
        .true         (true),
        .true_q       (true_q),
        .check        (check),
        .exp_val      (exp_val),
        .chk_op       (chk_op),
        .is_right     (is_right),
        .is_right_vld (is_right_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] o, input logic e);
        @(negedge clk);
        arg0 = a;
        arg1 = b;
        op   = o;
        #1;
        check_val(tag, {31'd0, true}, {31'd0, e});
        @(posedge clk);
        #1;
        check_val({tag, "_q"}, {31'd0, true_q}, {31'd0, e});
    endtask

    task automatic grade_step(input string tag, input logic exp_right, input logic exp_vld);
        @(posedge clk);
        #1;
        check_val({tag, "_vld"}, {31'd0, is_right_vld}, {31'd0, exp_vld});
        check_val({tag, "_right"}, {31'd0, is_right}, {31'd0, exp_right});
    endtask

    logic seen_vld;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        arg0    = 32'd0;
        arg1    = 32'd0;
        op      = 3'b000;
        check   = 1'b1;
        exp_val = 1'b0;
        chk_op  = 1'b0;
        #12;
        check_val("rst_true_q", {31'd0, true_q}, 32'd0);
        check_val("rst_is_right", {31'd0, is_right}, 32'd0);
        check_val("rst_vld", {31'd0, is_right_vld}, 32'd0);

        // check held high through reset release must not grade
        @(negedge clk);
        reset = 1'b0;
        seen_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (is_right_vld) seen_vld = 1'b1;
        end
        check_val("no_vld_after_reset", {31'd0, seen_vld}, 32'd0);

        run_vec("eq_same",      32'h00010000, 32'h00010000, 3'b000, 1'b1);
        run_vec("eq_diff",      32'h00001056, 32'h10561056, 3'b000, 1'b0);
        run_vec("ne_diff",      32'h00001056, 32'h10561056, 3'b001, 1'b1);
        run_vec("ne_same",      32'h12345678, 32'h12345678, 3'b001, 1'b0);
        run_vec("lt_min_1",     32'h80000000, 32'h00000001, 3'b100, 1'b1);
        run_vec("lt_min_min1",  32'h80000000, 32'h80000001, 3'b100, 1'b1);
        run_vec("lt_m1_0",      32'hFFFFFFFF, 32'h00000000, 3'b100, 1'b1);
        run_vec("lt_min_max",   32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b1);
        run_vec("lt_1_min",     32'h00000001, 32'h80000000, 3'b100, 1'b0);
        run_vec("ltu_min_1",    32'h80000000, 32'h00000001, 3'b110, 1'b0);
        run_vec("ltu_min_min1", 32'h80000000, 32'h80000001, 3'b110, 1'b1);
        run_vec("ltu_m1_0",     32'hFFFFFFFF, 32'h00000000, 3'b110, 1'b0);
        run_vec("ge_0_0",       32'h00000000, 32'h00000000, 3'b101, 1'b1);
        run_vec("ge_m1_0",      32'hFFFFFFFF, 32'h00000000, 3'b101, 1'b0);
        run_vec("ge_max_min",   32'h7FFFFFFF, 32'h80000000, 3'b101, 1'b1);
        run_vec("geu_m1_0",     32'hFFFFFFFF, 32'h00000000, 3'b111, 1'b1);
        run_vec("geu_min_min1", 32'h80000000, 32'h80000001, 3'b111, 1'b0);
        run_vec("rsv_010",      32'h0000ABCD, 32'h0000ABCD, 3'b010, 1'b0);
        run_vec("rsv_011",      32'h0000ABCD, 32'h0000ABCD, 3'b011, 1'b0);

        check_val("no_vld_during_vectors", {31'd0, is_right_vld}, 32'd0);

        // matching grade, EQ mode
        @(negedge clk);
        arg0 = 32'd5; arg1 = 32'd5; op = 3'b000;
        exp_val = 1'b1; chk_op = 1'b0; check = 1'b0;
        grade_step("grade_eq_pass", 1'b1, 1'b1);
        grade_step("grade_hold", 1'b1, 1'b0);

        // mismatching grade, EQ mode
        @(negedge clk);
        exp_val = 1'b0; check = 1'b1;
        grade_step("grade_eq_fail", 1'b0, 1'b1);

        // NEQ mode: 0 NE FFFFFFFF is 1, exp_val 0 -> pass
        @(negedge clk);
        arg0 = 32'h0; arg1 = 32'hFFFFFFFF; op = 3'b001;
        chk_op = 1'b1; exp_val = 1'b0; check = 1'b0;
        grade_step("grade_neq_pass", 1'b1, 1'b1);
        // back-to-back toggle, now expecting 1 so NEQ fails
        @(negedge clk);
        exp_val = 1'b1; check = 1'b1;
        grade_step("grade_b2b", 1'b0, 1'b1);
        @(negedge clk);
        exp_val = 1'b0; check = 1'b0;
        grade_step("grade_b2b2", 1'b1, 1'b1);

        // asynchronous reset mid-sequence with a toggle pending
        @(negedge clk);
        check = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_true_q", {31'd0, true_q}, 32'd0);
        check_val("mid_rst_is_right", {31'd0, is_right}, 32'd0);
        check_val("mid_rst_vld", {31'd0, is_right_vld}, 32'd0);
        check_val("mid_rst_true_comb", {31'd0, true}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        seen_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (is_right_vld) seen_vld = 1'b1;
        end
        check_val("no_vld_after_mid_rst", {31'd0, seen_vld}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
